// File: rtl/axi_write_ctrl.sv
// AXI3 write-channel master for cache line writebacks (16 beats) and single uncached stores.
// Define AXI_AW_W_PARALLEL_EN to issue AW and W concurrently instead of strictly AW-then-W.
module axi_write_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_burst,
    input  logic [3:0]  req_strb,
    input  logic [31:0] req_wdata,
    input  logic        req_wvalid,
    output logic        req_wready,
    output logic        done,
    output logic        err,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        DATA      = 3'd2,
        RESP      = 3'd3,
        ADDR_DATA = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_addr;
    logic        r_burst;
    logic [3:0]  r_strb;
    logic [3:0]  r_beat_cnt;

    logic        w_aw_active;
    logic        w_w_active;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_last_beat;
    logic        w_w_last_hs;
    logic [7:0]  w_awlen;
    logic        w_unused_bid;

`ifdef AXI_AW_W_PARALLEL_EN
    logic        r_aw_done;
    logic        r_w_done;
`endif

    // Write ID is fixed, so the returned ID carries no information.
    assign w_unused_bid = ^bid;

    always_comb begin
        w_aw_active = 1'b0;
        w_w_active  = 1'b0;
        case (r_state)
            ADDR: w_aw_active = 1'b1;
            DATA: w_w_active  = 1'b1;
`ifdef AXI_AW_W_PARALLEL_EN
            ADDR_DATA: begin
                w_aw_active = ~r_aw_done;
                w_w_active  = ~r_w_done;
            end
`endif
            default: ;
        endcase
    end

    assign w_awlen     = r_burst ? 8'h0f : 8'h00;
    assign w_aw_hs     = w_aw_active & awready;
    assign w_w_hs      = w_w_active & req_wvalid & wready;
    assign w_last_beat = (r_beat_cnt == w_awlen[3:0]);
    assign w_w_last_hs = w_w_hs & w_last_beat;

    assign req_ready  = (r_state == IDLE);

    assign awid       = 4'h1;
    assign awsize     = 3'b010;
    assign awlock     = 2'b00;
    assign awcache    = 4'h0;
    assign awprot     = 3'b000;
    assign awvalid    = w_aw_active;
    // Line writebacks are always issued line-aligned (64 bytes).
    assign awaddr     = r_burst ? {r_addr[31:6], 6'b0} : r_addr;
    assign awlen      = w_awlen;
    assign awburst    = r_burst ? 2'b01 : 2'b00;

    assign wid        = w_w_active ? 4'h1 : 4'h0;
    assign wvalid     = w_w_active & req_wvalid;
    assign wdata      = w_w_active ? req_wdata : 32'h0;
    assign wstrb      = w_w_active ? (r_burst ? 4'hf : r_strb) : 4'h0;
    assign wlast      = w_w_active & w_last_beat;
    assign req_wready = w_w_active & wready;

    assign bready     = (r_state == RESP);
    assign done       = (r_state == RESP) & bvalid;
    assign err        = done & (bresp != 2'b00);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
`ifdef AXI_AW_W_PARALLEL_EN
                    w_next_state = ADDR_DATA;
`else
                    w_next_state = ADDR;
`endif
                end
            end
            ADDR: begin
                if (awready) w_next_state = DATA;
            end
            DATA: begin
                if (w_w_last_hs) w_next_state = RESP;
            end
            RESP: begin
                if (bvalid) w_next_state = IDLE;
            end
`ifdef AXI_AW_W_PARALLEL_EN
            ADDR_DATA: begin
                if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_last_hs))
                    w_next_state = RESP;
            end
`endif
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= 32'h0;
            r_burst    <= 1'b0;
            r_strb     <= 4'h0;
            r_beat_cnt <= 4'h0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && req_valid) begin
                r_addr  <= req_addr;
                r_burst <= req_burst;
                r_strb  <= req_strb;
            end
            // A stalled beat leaves the counter untouched, so beats are never skipped.
            if (w_next_state == IDLE)
                r_beat_cnt <= 4'h0;
            else if (w_w_hs)
                r_beat_cnt <= r_beat_cnt + 4'h1;
        end
    end

`ifdef AXI_AW_W_PARALLEL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (w_next_state == IDLE) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_hs)     r_aw_done <= 1'b1;
            if (w_w_last_hs) r_w_done  <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_write_ctrl.sv
// Directed bench for axi_write_ctrl: single/line writes, stalls, error responses, mid-burst reset.
// Build with AXI_AW_W_PARALLEL_EN to add the overlapped AW/W scenario.
module tb_axi_write_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_burst;
    logic [3:0]  req_strb;
    logic [31:0] req_wdata;
    logic        req_wvalid;
    logic        req_wready;
    logic        done;
    logic        err;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int checks = 0;
    int errors = 0;

    axi_write_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_burst(req_burst), .req_strb(req_strb),
        .req_wdata(req_wdata), .req_wvalid(req_wvalid), .req_wready(req_wready),
        .done(done), .err(err),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus monitor: records every handshake seen on the AXI side.
    int          m_beats   = 0;
    int          aw_hs_cnt = 0;
    int          done_cnt  = 0;
    int          w_early   = 0;
    int          b_early   = 0;
    logic        aw_open   = 1'b0;
    logic [31:0] m_data [256];
    logic        m_last [256];
    logic [3:0]  m_strb [256];
    logic [3:0]  m_wid;
    logic [31:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [1:0]  m_awburst;
    logic [3:0]  m_awid;
    logic [2:0]  m_awsize;
    logic [8:0]  m_awmisc;

    always @(posedge clk) begin
        if (rst) begin
            aw_open <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                aw_hs_cnt <= aw_hs_cnt + 1;
                m_awaddr  <= awaddr;
                m_awlen   <= awlen;
                m_awburst <= awburst;
                m_awid    <= awid;
                m_awsize  <= awsize;
                m_awmisc  <= {awlock, awcache, awprot};
                aw_open   <= 1'b1;
            end
            if (wvalid && wready) begin
                m_data[m_beats[7:0]] <= wdata;
                m_last[m_beats[7:0]] <= wlast;
                m_strb[m_beats[7:0]] <= wstrb;
                m_wid   <= wid;
                m_beats <= m_beats + 1;
                if (!aw_open && !(awvalid && awready)) w_early <= w_early + 1;
            end
            if (bready && bvalid && !aw_open) b_early <= b_early + 1;
            if (done) begin
                done_cnt <= done_cnt + 1;
                aw_open  <= 1'b0;
            end
        end
    end

    // Drives one request from just after a falling edge; returns just after the
    // falling edge following the done cycle (or just after the reset edge on abort).
    task automatic drive_txn(input logic [31:0] addr, input logic burst, input logic [3:0] strb,
                             input int aw_delay, input bit wr_toggle, input bit wv_gaps,
                             input logic [1:0] bresp_v, input int abort_beats,
                             output bit accepted, output bit got_done, output bit got_err,
                             output int aw_cycles);
        int beat_base;
        beat_base = m_beats;
        accepted  = req_ready;
        got_done  = 1'b0;
        got_err   = 1'b0;
        aw_cycles = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        req_burst = burst;
        req_strb  = strb;
        @(negedge clk);
        req_valid = 1'b0;
        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            awready    = (aw_cycles >= aw_delay);
            wready     = wr_toggle ? (cyc % 2 == 1) : 1'b1;
            req_wvalid = wv_gaps ? (cyc % 7 != 3) : 1'b1;
            req_wdata  = 32'hA000_0000 + 32'(m_beats - beat_base);
            bvalid     = 1'b1;
            bresp      = bresp_v;
            if (abort_beats >= 0 && (m_beats - beat_base) == abort_beats) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            #1;
            if (awvalid) aw_cycles++;
            if (done) begin
                got_done = 1'b1;
                got_err  = err;
            end
            @(negedge clk);
        end
        bvalid     = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        req_wvalid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if ({awvalid, wvalid, bready} !== 3'b000) begin errors++; $display("FAIL reset_valids got %b want 000", {awvalid, wvalid, bready}); end
        checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL reset_done_err got %b want 00", {done, err}); end
        checks++; if ({req_wready, wlast, wstrb} !== 6'b0) begin errors++; $display("FAIL reset_w_outputs got %b want 0", {req_wready, wlast, wstrb}); end
    endtask

    task automatic test_single();
        int b0, a0, d0, e0, awc;
        bit acc, gd, ge;
        b0 = m_beats; a0 = aw_hs_cnt; d0 = done_cnt; e0 = w_early;
        drive_txn(32'h1fc0_0004, 1'b0, 4'b0011, 0, 1'b0, 1'b0, 2'b00, -1, acc, gd, ge, awc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", acc); end
        checks++; if (aw_hs_cnt - a0 != 1) begin errors++; $display("FAIL single_aw_count got %0d want 1", aw_hs_cnt - a0); end
        checks++; if (m_awaddr !== 32'h1fc0_0004) begin errors++; $display("FAIL single_awaddr got %h want 1fc00004", m_awaddr); end
        checks++; if ({m_awlen, m_awburst} !== 10'h000) begin errors++; $display("FAIL single_awlen_burst got %h/%b want 00/00", m_awlen, m_awburst); end
        checks++; if ({m_awid, m_awsize, m_awmisc} !== {4'h1, 3'b010, 9'h0}) begin errors++; $display("FAIL single_aw_consts got %h %b %h want 1 010 000", m_awid, m_awsize, m_awmisc); end
        checks++; if (m_beats - b0 != 1) begin errors++; $display("FAIL single_beats got %0d want 1", m_beats - b0); end
        checks++; if ({m_data[b0[7:0]], m_last[b0[7:0]], m_strb[b0[7:0]], m_wid} !== {32'hA000_0000, 1'b1, 4'b0011, 4'h1})
            begin errors++; $display("FAIL single_beat got data %h last %b strb %b wid %h want a0000000 1 0011 1", m_data[b0[7:0]], m_last[b0[7:0]], m_strb[b0[7:0]], m_wid); end
        checks++; if ({gd, ge} !== 2'b10) begin errors++; $display("FAIL single_done_err got %b want 10", {gd, ge}); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done_pulses got %0d want 1", done_cnt - d0); end
`ifndef AXI_AW_W_PARALLEL_EN
        checks++; if (w_early - e0 != 0) begin errors++; $display("FAIL single_w_before_aw got %0d want 0", w_early - e0); end
`endif
    endtask

    task automatic test_line();
        int b0, d0, awc;
        bit acc, gd, ge;
        b0 = m_beats; d0 = done_cnt;
        drive_txn(32'h0000_1234, 1'b1, 4'b0001, 0, 1'b0, 1'b0, 2'b00, -1, acc, gd, ge, awc);
        checks++; if (m_awaddr !== 32'h0000_1200) begin errors++; $display("FAIL line_awaddr got %h want 00001200", m_awaddr); end
        checks++; if ({m_awlen, m_awburst} !== {8'h0f, 2'b01}) begin errors++; $display("FAIL line_awlen_burst got %h/%b want 0f/01", m_awlen, m_awburst); end
        checks++; if (m_beats - b0 != 16) begin errors++; $display("FAIL line_beats got %0d want 16", m_beats - b0); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({m_data[(b0 + i) % 256], m_last[(b0 + i) % 256], m_strb[(b0 + i) % 256]} !== {32'hA000_0000 + 32'(i), (i == 15), 4'hf})
                begin errors++; $display("FAIL line_beat%0d got %h last %b strb %b want %h last %b strb 1111", i, m_data[(b0 + i) % 256], m_last[(b0 + i) % 256], m_strb[(b0 + i) % 256], 32'hA000_0000 + 32'(i), (i == 15)); end
        end
        checks++; if ({gd, ge} !== 2'b10 || done_cnt - d0 != 1) begin errors++; $display("FAIL line_done got %b pulses %0d want 10 pulses 1", {gd, ge}, done_cnt - d0); end
    endtask

    task automatic test_line_stall();
        int b0, e0, awc;
        bit acc, gd, ge;
        b0 = m_beats; e0 = w_early;
        drive_txn(32'h8000_0fc8, 1'b1, 4'b0000, 3, 1'b1, 1'b1, 2'b00, -1, acc, gd, ge, awc);
        checks++; if (awc != 4) begin errors++; $display("FAIL stall_awvalid_cycles got %0d want 4", awc); end
        checks++; if (m_awaddr !== 32'h8000_0fc0) begin errors++; $display("FAIL stall_awaddr got %h want 80000fc0", m_awaddr); end
        checks++; if (m_beats - b0 != 16) begin errors++; $display("FAIL stall_beats got %0d want 16", m_beats - b0); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({m_data[(b0 + i) % 256], m_last[(b0 + i) % 256]} !== {32'hA000_0000 + 32'(i), (i == 15)})
                begin errors++; $display("FAIL stall_beat%0d got %h last %b want %h last %b", i, m_data[(b0 + i) % 256], m_last[(b0 + i) % 256], 32'hA000_0000 + 32'(i), (i == 15)); end
        end
        checks++; if (gd !== 1'b1) begin errors++; $display("FAIL stall_done got %b want 1", gd); end
`ifndef AXI_AW_W_PARALLEL_EN
        checks++; if (w_early - e0 != 0) begin errors++; $display("FAIL stall_w_before_aw got %0d want 0", w_early - e0); end
`endif
    endtask

    task automatic test_err_resp();
        int awc;
        bit acc, gd, ge;
        drive_txn(32'h0000_0040, 1'b0, 4'b1100, 1, 1'b0, 1'b0, 2'b10, -1, acc, gd, ge, awc);
        checks++; if ({gd, ge} !== 2'b11) begin errors++; $display("FAIL slverr_done_err got %b want 11", {gd, ge}); end
        checks++; if ({req_ready, done, bready} !== 3'b100) begin errors++; $display("FAIL slverr_idle_next got rdy/done/bready %b want 100", {req_ready, done, bready}); end
        drive_txn(32'h0000_0044, 1'b0, 4'b1111, 0, 1'b0, 1'b0, 2'b01, -1, acc, gd, ge, awc);
        checks++; if ({gd, ge} !== 2'b11) begin errors++; $display("FAIL exokay_done_err got %b want 11", {gd, ge}); end
    endtask

    task automatic test_back_to_back();
        int d0, b0, awc;
        bit acc, gd, ge;
        d0 = done_cnt; b0 = m_beats;
        for (int k = 0; k < 3; k++) begin
            drive_txn(32'h0000_0100 + 32'(4 * k), 1'b0, 4'hf, k, 1'b0, 1'b0, 2'b00, -1, acc, gd, ge, awc);
            checks++; if ({acc, gd, ge} !== 3'b110) begin errors++; $display("FAIL b2b_txn%0d got acc/done/err %b want 110", k, {acc, gd, ge}); end
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_done%0d got %b want 1", k, req_ready); end
        end
        checks++; if (done_cnt - d0 != 3 || m_beats - b0 != 3) begin errors++; $display("FAIL b2b_totals got done %0d beats %0d want 3 3", done_cnt - d0, m_beats - b0); end
    endtask

    task automatic test_reset_mid_burst();
        int d0, b0, awc;
        bit acc, gd, ge;
        d0 = done_cnt; b0 = m_beats;
        drive_txn(32'h0000_2000, 1'b1, 4'h0, 0, 1'b0, 1'b0, 2'b00, 7, acc, gd, ge, awc);
        checks++; if (m_beats - b0 != 7) begin errors++; $display("FAIL abort_beats got %0d want 7", m_beats - b0); end
        checks++; if ({awvalid, wvalid, bready} !== 3'b000) begin errors++; $display("FAIL abort_valids got %b want 000", {awvalid, wvalid, bready}); end
        checks++; if ({req_ready, done} !== 2'b10) begin errors++; $display("FAIL abort_ready_done got %b want 10", {req_ready, done}); end
        bvalid = 1'b0; awready = 1'b0; wready = 1'b0; req_wvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || done_cnt != d0) begin errors++; $display("FAIL abort_no_done got ready %b pulses %0d want 1 0", req_ready, done_cnt - d0); end
        b0 = m_beats;
        drive_txn(32'h0000_3008, 1'b0, 4'b0110, 0, 1'b0, 1'b0, 2'b00, -1, acc, gd, ge, awc);
        checks++; if ({acc, gd} !== 2'b11 || m_beats - b0 != 1 || m_strb[b0[7:0]] !== 4'b0110)
            begin errors++; $display("FAIL abort_recovery got acc/done %b beats %0d strb %b want 11 1 0110", {acc, gd}, m_beats - b0, m_strb[b0[7:0]]); end
    endtask

`ifdef AXI_AW_W_PARALLEL_EN
    task automatic test_parallel();
        int e0, be0, b0, awc;
        bit acc, gd, ge;
        e0 = w_early; be0 = b_early; b0 = m_beats;
        drive_txn(32'h0000_0500, 1'b0, 4'hf, 5, 1'b0, 1'b0, 2'b00, -1, acc, gd, ge, awc);
        checks++; if (awc != 6) begin errors++; $display("FAIL par_awvalid_cycles got %0d want 6", awc); end
        checks++; if (w_early - e0 != 1 || m_beats - b0 != 1) begin errors++; $display("FAIL par_w_first got early %0d beats %0d want 1 1", w_early - e0, m_beats - b0); end
        checks++; if (b_early - be0 != 0 || gd !== 1'b1) begin errors++; $display("FAIL par_resp_after_aw got early_b %0d done %b want 0 1", b_early - be0, gd); end
        e0 = w_early; b0 = m_beats;
        drive_txn(32'h0000_0600, 1'b1, 4'h0, 5, 1'b0, 1'b0, 2'b00, -1, acc, gd, ge, awc);
        checks++; if (w_early - e0 != 5 || m_beats - b0 != 16 || b_early - be0 != 0)
            begin errors++; $display("FAIL par_line got early %0d beats %0d early_b %0d want 5 16 0", w_early - e0, m_beats - b0, b_early - be0); end
    endtask
`endif

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_burst = 1'b0; req_strb = 4'h0;
        req_wdata = 32'h0; req_wvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        bid = 4'h7; bresp = 2'b00; bvalid = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_line();
        test_line_stall();
        test_err_resp();
        test_back_to_back();
        test_reset_mid_burst();
`ifdef AXI_AW_W_PARALLEL_EN
        test_parallel();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule
